// File: rtl/game_pkg.sv
// Shared constants and state encoding for the game datapath.
package game_pkg;

  localparam int unsigned SCREEN_W       = 160;
  localparam int unsigned SCREEN_H_DFLT  = 120;

  localparam logic [2:0] COLOUR_BG     = 3'b000;
  localparam logic [2:0] COLOUR_PLAYER = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StWaitFrame,
    StErase,
    StUpdate,
    StDraw,
    StCheck,
    StDone
  } dp_state_e;

endpackage

// File: rtl/sprite_sweep.sv
// Walks a 4x4 square one pixel per cycle; pixel outputs are registered.
module sprite_sweep
  import game_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,      // held high for the whole sweep
  input  logic       write_en,
  input  logic [7:0] pos_x,
  input  logic [6:0] pos_y,
  input  logic [2:0] colour_in,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       done        // high on the cycle holding the last counter value
);

  logic [3:0] cnt_q, cnt_d;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [2:0] colour_q;
  logic       plot_q;

  // Counter advances while the sweep is requested and restarts from 0 otherwise
  always_comb begin
    cnt_d = start ? cnt_q + 4'd1 : 4'd0;
  end

  // Counter register
  always_ff @(posedge clock) begin
    if (!resetn) cnt_q <= 4'd0;
    else         cnt_q <= cnt_d;
  end

  assign done = start && (cnt_q == 4'hf);

  // Registered pixel: counter value n appears on the outputs one cycle later
  always_ff @(posedge clock) begin
    if (!resetn) begin
      x_q      <= 8'd0;
      y_q      <= 7'd0;
      colour_q <= 3'd0;
      plot_q   <= 1'b0;
    end else begin
      plot_q <= start & write_en;
      if (start) begin
        x_q      <= pos_x + {6'd0, cnt_q[1:0]};
        y_q      <= pos_y + {5'd0, cnt_q[3:2]};
        colour_q <= colour_in;
      end
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;

endmodule

// File: rtl/player_datapath.sv
// Player square datapath: frame timing, movement, erase/draw sweeps, end/collision detect.
module player_datapath
  import game_pkg::*;
#(
  parameter int unsigned SCREEN_H    = SCREEN_H_DFLT,
  parameter int unsigned SPRITE      = 4,
  parameter int unsigned START_X     = 0,
  parameter int unsigned START_Y     = 56,
  parameter int unsigned END_X       = 156,
  parameter int unsigned OBS_X       = 80,
  parameter int unsigned OBS_Y       = 40,
  parameter int unsigned OBS_W       = 8,
  parameter int unsigned OBS_H       = 40,
  parameter int unsigned FRAME_TICKS = 833333
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       draw,
  input  logic       writeEnable,
  input  logic       up,
  input  logic       down,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       finish
);

  localparam int unsigned     TickW    = $clog2(FRAME_TICKS + 1);
  localparam logic [TickW-1:0] TickLoad = TickW'(FRAME_TICKS - 1);
  localparam logic [6:0]      YMax     = 7'(SCREEN_H - SPRITE);
  localparam logic [7:0]      EndX     = 8'(END_X);
  localparam logic [8:0]      ObsXBeg  = 9'(OBS_X);
  localparam logic [8:0]      ObsXEnd  = 9'(OBS_X + OBS_W);
  localparam logic [7:0]      ObsYBeg  = 8'(OBS_Y);
  localparam logic [7:0]      ObsYEnd  = 8'(OBS_Y + OBS_H);

  dp_state_e        state_q, state_d;
  logic [7:0]       pos_x_q;
  logic [6:0]       pos_y_q;
  logic [TickW-1:0] tick_q;
  logic             finish_q;

  logic       sweep_start, sweep_done, load_tick, hit;
  logic [2:0] sweep_colour;
  logic [8:0] px9;
  logic [7:0] py8;

  // Half-open overlap test, widened so pos + SPRITE cannot wrap
  assign px9 = {1'b0, pos_x_q};
  assign py8 = {1'b0, pos_y_q};
  assign hit = (pos_x_q == EndX) ||
               ((px9 < ObsXEnd) && (px9 + 9'(SPRITE) > ObsXBeg) &&
                (py8 < ObsYEnd) && (py8 + 8'(SPRITE) > ObsYBeg));

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (draw) state_d = StDraw;
      StWaitFrame: begin
        if (!draw)              state_d = StIdle;
        else if (tick_q == '0)  state_d = StErase;
      end
      StErase:     if (sweep_done) state_d = StUpdate;
      StUpdate:    state_d = StDraw;
      StDraw:      if (sweep_done) state_d = StCheck;
      StCheck: begin
        if (hit)       state_d = StDone;
        else if (draw) state_d = StWaitFrame;
        else           state_d = StIdle;
      end
      StDone:      state_d = StDone;
      default:     state_d = StIdle;
    endcase
  end

  // Control outputs decoded from the current state
  always_comb begin
    sweep_start  = (state_q == StErase) || (state_q == StDraw);
    sweep_colour = (state_q == StDraw) ? COLOUR_PLAYER : COLOUR_BG;
    load_tick    = ((state_q == StIdle) && draw) || ((state_q == StCheck) && !hit && draw);
  end

  // Position, frame tick counter and sticky finish
  always_ff @(posedge clock) begin
    if (!resetn) begin
      pos_x_q  <= 8'(START_X);
      pos_y_q  <= 7'(START_Y);
      tick_q   <= '0;
      finish_q <= 1'b0;
    end else begin
      if (load_tick) begin
        tick_q <= TickLoad;
      end else if ((state_q == StWaitFrame) && (tick_q != '0)) begin
        tick_q <= tick_q - 1'b1;
      end
      if (state_q == StUpdate) begin
        pos_x_q <= pos_x_q + 8'd1;
        // Clamp decided before the step so pos_y never wraps
        if (up && !down && (pos_y_q != 7'd0)) begin
          pos_y_q <= pos_y_q - 7'd1;
        end else if (down && !up && (pos_y_q < YMax)) begin
          pos_y_q <= pos_y_q + 7'd1;
        end
      end
      if ((state_q == StCheck) && hit) finish_q <= 1'b1;
    end
  end

  sprite_sweep u_sweep (
    .clock     (clock),
    .resetn    (resetn),
    .start     (sweep_start),
    .write_en  (writeEnable),
    .pos_x     (pos_x_q),
    .pos_y     (pos_y_q),
    .colour_in (sweep_colour),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .done      (sweep_done)
  );

  assign finish = finish_q;

endmodule
